// File: rtl/fpu_wb_pkg.sv
// Shared types and constants for the FPU writeback/retire block.
package fpu_wb_pkg;

    // Retire FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FPR_WR  = 2'd1,
        ST_GPR_REQ = 2'd2
    } retire_state_t;

    // Bit positions inside fflags / cpl_flags
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Destination tag captured at dispatch
    typedef struct packed {
        logic       to_gpr;
        logic [4:0] rd;
    } tag_entry_t;

    // Paired tag + result waiting to retire
    typedef struct packed {
        logic        to_gpr;
        logic [4:0]  rd;
        logic [31:0] data;
    } result_entry_t;

    // State the retire FSM should enter for a given FIFO head
    function automatic retire_state_t entry_state(input logic valid, input logic to_gpr);
        if (!valid) return ST_IDLE;
        return to_gpr ? ST_GPR_REQ : ST_FPR_WR;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Parameterised synchronous FIFO. Push and pop in the same cycle are legal
// at any occupancy; a pop on an empty FIFO is ignored, a push on a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
// peek exposes the entry behind the head so a consumer can look one ahead.
module fpu_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [WIDTH-1:0]         peek,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign dout       = mem[rd_ptr];
    assign peek       = mem[rd_ptr_nxt];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_wb_retire.sv
// FPU writeback/retire: pairs dispatch tags with the in-order completion
// stream, retires FPR results to the FP regfile and GPR results through a
// valid/ready port, accrues fflags and provides dispatch credit.
// Optional macro FPU_WB_BYPASS_EN: an FPR completion arriving while nothing
// is queued and the FSM is idle is written in the completion cycle itself.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | result FIFO empty or just filled; pick path from head
// ST_FPR_WR  | fpr_we high this cycle for the head entry, then pop
// ST_GPR_REQ | gpr_wb_valid high, head held until gpr_wb_ready
module fpu_wb_retire
    import fpu_wb_pkg::*;
#(
    parameter int FPLEN = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [4:0]       disp_rd,
    input  logic             disp_to_gpr,
    output logic             disp_ready,
    input  logic             cpl_valid,
    input  logic             cpl_rd_valid,
    input  logic [FPLEN-1:0] cpl_fpr_data,
    input  logic [31:0]      cpl_gpr_data,
    input  logic [4:0]       cpl_flags,
    input  logic             cpl_iv_exc,
    output logic             fpr_we,
    output logic [4:0]       fpr_waddr,
    output logic [FPLEN-1:0] fpr_wdata,
    output logic             gpr_wb_valid,
    input  logic             gpr_wb_ready,
    output logic [4:0]       gpr_wb_addr,
    output logic [31:0]      gpr_wb_data,
    input  logic             csr_fflags_we,
    input  logic [4:0]       csr_fflags_wdata,
    output logic [4:0]       fflags,
    output logic             iv_exc_pend,
    output logic             wb_err,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $bits(tag_entry_t);
    localparam int RW = $bits(result_entry_t);

    logic [CW-1:0]  credit_q;
    retire_state_t  state_q, state_d;

    tag_entry_t     tag_din, tag_head;
    logic [TW-1:0]  tag_dout_raw, tag_peek_raw;
    logic [CW-1:0]  tag_count;
    logic           tag_push, tag_pop, tag_full, tag_empty;

    result_entry_t  res_din, res_head, res_peek;
    logic [RW-1:0]  res_dout_raw, res_peek_raw;
    logic [CW-1:0]  res_count;
    logic           res_push, res_pop, res_full, res_empty;

    logic           cpl_accept, bypass_fire, fsm_fpr_we, retire;
    logic           post_valid;
    result_entry_t  post_head;
    logic           flag_pend_q;
    logic           unused_tag;

    assign unused_tag = ^{tag_peek_raw, tag_count};

    assign disp_ready = (credit_q != '0);
    assign tag_push   = disp_valid & disp_ready;
    assign tag_din    = '{to_gpr: disp_to_gpr, rd: disp_rd};
    assign tag_head   = tag_entry_t'(tag_dout_raw);

    assign cpl_accept = cpl_valid & ~tag_empty;
    assign tag_pop    = cpl_accept;

`ifdef FPU_WB_BYPASS_EN
    assign bypass_fire = cpl_accept & res_empty & (state_q == ST_IDLE) & ~tag_head.to_gpr;
`else
    assign bypass_fire = 1'b0;
`endif

    // The tag decides the destination even when the completion disagrees
    assign res_din.to_gpr = tag_head.to_gpr;
    assign res_din.rd     = tag_head.rd;
    assign res_din.data   = tag_head.to_gpr ? cpl_gpr_data : 32'(cpl_fpr_data);
    assign res_push       = cpl_accept & ~bypass_fire;
    assign res_head       = result_entry_t'(res_dout_raw);
    assign res_peek       = result_entry_t'(res_peek_raw);

    fpu_wb_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .din   (tag_din),
        .pop   (tag_pop),
        .dout  (tag_dout_raw),
        .peek  (tag_peek_raw),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fpu_wb_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (res_din),
        .pop   (res_pop),
        .dout  (res_dout_raw),
        .peek  (res_peek_raw),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // Head as it will look after popping the current one (enables 1/cycle retire)
    always_comb begin
        post_valid = 1'b0;
        post_head  = res_peek;
        if (res_count > CW'(1)) begin
            post_valid = 1'b1;
            post_head  = res_peek;
        end else if (res_push) begin
            post_valid = 1'b1;
            post_head  = res_din;
        end
    end

    // Retire FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Retire FSM next-state and outputs
    always_comb begin
        state_d      = state_q;
        fsm_fpr_we   = 1'b0;
        gpr_wb_valid = 1'b0;
        res_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = entry_state(~res_empty, res_head.to_gpr);
            end
            ST_FPR_WR: begin
                fsm_fpr_we = 1'b1;
                res_pop    = 1'b1;
                state_d    = entry_state(post_valid, post_head.to_gpr);
            end
            ST_GPR_REQ: begin
                gpr_wb_valid = 1'b1;
                if (gpr_wb_ready) begin
                    res_pop = 1'b1;
                    state_d = entry_state(post_valid, post_head.to_gpr);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fpr_we      = fsm_fpr_we | bypass_fire;
    assign fpr_waddr   = bypass_fire ? tag_head.rd  : res_head.rd;
    assign fpr_wdata   = bypass_fire ? cpl_fpr_data : res_head.data[FPLEN-1:0];
    assign gpr_wb_addr = res_head.rd;
    assign gpr_wb_data = res_head.data;
    assign retire      = fpr_we | (gpr_wb_valid & gpr_wb_ready);

    // Credit tracks free slots across tags in flight and unretired results
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= CW'(DEPTH);
        end else begin
            case ({tag_push, retire})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01:   credit_q <= credit_q + 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Sticky protocol error: dispatch without credit, orphan or mismatched
    // completion, or a FIFO overflow that credit should have prevented
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if ((disp_valid & ~disp_ready)
                   | (cpl_valid & tag_empty)
                   | (cpl_accept & (cpl_rd_valid != tag_head.to_gpr))
                   | (tag_push & tag_full & ~tag_pop)
                   | (res_push & res_full & ~res_pop)) begin
            wb_err <= 1'b1;
        end
    end

    // Flags arrive one cycle after the completion; a CSR write in that
    // cycle replaces the accrued value but still keeps the arriving flags
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_pend_q <= 1'b0;
            fflags      <= '0;
            iv_exc_pend <= 1'b0;
        end else begin
            flag_pend_q <= cpl_valid;
            if (csr_fflags_we)
                fflags <= csr_fflags_wdata | (flag_pend_q ? cpl_flags : 5'b0);
            else if (flag_pend_q)
                fflags <= fflags | cpl_flags;
            iv_exc_pend <= (iv_exc_pend & ~csr_fflags_we) | (cpl_valid & cpl_iv_exc);
        end
    end

    assign busy = ~tag_empty | ~res_empty | flag_pend_q;

endmodule

// File: tb/tb_fpu_wb_retire.sv
// Directed bench for fpu_wb_retire (DEPTH=4, FPLEN=16).
module tb_fpu_wb_retire;
`ifdef FPU_WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid, disp_to_gpr, disp_ready;
    logic [4:0]  disp_rd;
    logic        cpl_valid, cpl_rd_valid, cpl_iv_exc;
    logic [15:0] cpl_fpr_data;
    logic [31:0] cpl_gpr_data;
    logic [4:0]  cpl_flags;
    logic        fpr_we;
    logic [4:0]  fpr_waddr;
    logic [15:0] fpr_wdata;
    logic        gpr_wb_valid, gpr_wb_ready;
    logic [4:0]  gpr_wb_addr;
    logic [31:0] gpr_wb_data;
    logic        csr_fflags_we;
    logic [4:0]  csr_fflags_wdata, fflags;
    logic        iv_exc_pend, wb_err, busy;

    int checks_total  = 0;
    int checks_passed = 0;

    fpu_wb_retire #(.FPLEN(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_to_gpr(disp_to_gpr),
        .disp_ready(disp_ready),
        .cpl_valid(cpl_valid), .cpl_rd_valid(cpl_rd_valid),
        .cpl_fpr_data(cpl_fpr_data), .cpl_gpr_data(cpl_gpr_data),
        .cpl_flags(cpl_flags), .cpl_iv_exc(cpl_iv_exc),
        .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
        .gpr_wb_valid(gpr_wb_valid), .gpr_wb_ready(gpr_wb_ready),
        .gpr_wb_addr(gpr_wb_addr), .gpr_wb_data(gpr_wb_data),
        .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
        .fflags(fflags), .iv_exc_pend(iv_exc_pend), .wb_err(wb_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_valid = 0; disp_rd = 0; disp_to_gpr = 0;
        cpl_valid = 0; cpl_rd_valid = 0; cpl_fpr_data = 0; cpl_gpr_data = 0;
        cpl_flags = 0; cpl_iv_exc = 0; gpr_wb_ready = 0;
        csr_fflags_we = 0; csr_fflags_wdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic to_gpr);
        disp_valid = 1; disp_rd = rd; disp_to_gpr = to_gpr;
        cyc();
        disp_valid = 0;
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks_total++; if (fpr_we !== 1'b0) $display("FAIL reset_fpr_we got %b want 0", fpr_we); else checks_passed++;
        checks_total++; if (gpr_wb_valid !== 1'b0) $display("FAIL reset_gpr_valid got %b want 0", gpr_wb_valid); else checks_passed++;
        checks_total++; if (fflags !== 5'b0) $display("FAIL reset_fflags got %b want 00000", fflags); else checks_passed++;
        checks_total++; if (iv_exc_pend !== 1'b0) $display("FAIL reset_iv got %b want 0", iv_exc_pend); else checks_passed++;
        checks_total++; if (wb_err !== 1'b0) $display("FAIL reset_wb_err got %b want 0", wb_err); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else checks_passed++;
        checks_total++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready got %b want 1", disp_ready); else checks_passed++;
    endtask

    task automatic test_fpr_single();
        do_reset();
        dispatch(5'd5, 1'b0);
        cpl_valid = 1; cpl_rd_valid = 0; cpl_fpr_data = 16'h3C00; cpl_gpr_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) cpl_valid = 0;
            #1;
            checks_total++; if (fpr_we !== (k == LAT)) $display("FAIL fpr_single_we k=%0d got %b want %b", k, fpr_we, (k == LAT)); else checks_passed++;
            if (k == LAT) begin
                checks_total++; if (fpr_waddr !== 5'd5) $display("FAIL fpr_single_addr got %0d want 5", fpr_waddr); else checks_passed++;
                checks_total++; if (fpr_wdata !== 16'h3C00) $display("FAIL fpr_single_data got %h want 3c00", fpr_wdata); else checks_passed++;
            end
            cyc();
        end
        checks_total++; if (busy !== 1'b0) $display("FAIL fpr_single_busy got %b want 0", busy); else checks_passed++;
    endtask

    task automatic test_gpr_stall();
        int hs;
        do_reset();
        dispatch(5'd10, 1'b1);
        cpl_valid = 1; cpl_rd_valid = 1; cpl_gpr_data = 32'h1; cpl_fpr_data = 16'h7777;
        gpr_wb_ready = 0; hs = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) cpl_valid = 0;
            if (k == 5) gpr_wb_ready = 1;
            #1;
            if (gpr_wb_valid && gpr_wb_ready) hs++;
            checks_total++; if (gpr_wb_valid !== (k >= 2 && k <= 5)) $display("FAIL gpr_stall_valid k=%0d got %b want %b", k, gpr_wb_valid, (k >= 2 && k <= 5)); else checks_passed++;
            if (k >= 2 && k <= 5) begin
                checks_total++; if (gpr_wb_addr !== 5'd10 || gpr_wb_data !== 32'h1) $display("FAIL gpr_stall_hold k=%0d got %0d/%h want 10/00000001", k, gpr_wb_addr, gpr_wb_data); else checks_passed++;
            end
            checks_total++; if (fpr_we !== 1'b0) $display("FAIL gpr_stall_fpr_we k=%0d got %b want 0", k, fpr_we); else checks_passed++;
            cyc();
        end
        gpr_wb_ready = 0;
        checks_total++; if (hs !== 1) $display("FAIL gpr_stall_handshakes got %0d want 1", hs); else checks_passed++;
        checks_total++; if (wb_err !== 1'b0) $display("FAIL gpr_stall_wb_err got %b want 0", wb_err); else checks_passed++;
    endtask

    task automatic test_gpr_x0();
        int hs;
        do_reset();
        dispatch(5'd0, 1'b1);
        cpl_valid = 1; cpl_rd_valid = 1; cpl_gpr_data = 32'hCAFE_0001; gpr_wb_ready = 1; hs = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) cpl_valid = 0;
            #1;
            if (gpr_wb_valid && gpr_wb_ready) begin
                hs++;
                checks_total++; if (gpr_wb_addr !== 5'd0 || gpr_wb_data !== 32'hCAFE_0001) $display("FAIL gpr_x0_payload got %0d/%h want 0/cafe0001", gpr_wb_addr, gpr_wb_data); else checks_passed++;
            end
            cyc();
        end
        gpr_wb_ready = 0;
        checks_total++; if (hs !== 1) $display("FAIL gpr_x0_handshakes got %0d want 1", hs); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d;
        do_reset();
        for (int i = 1; i <= 4; i++) dispatch(5'(i), 1'b0);
        checks_total++; if (disp_ready !== 1'b0) $display("FAIL full_disp_ready got %b want 0", disp_ready); else checks_passed++;
        checks_total++; if (wb_err !== 1'b0) $display("FAIL full_wb_err_pre got %b want 0", wb_err); else checks_passed++;
        dispatch(5'd9, 1'b0);
        checks_total++; if (wb_err !== 1'b1) $display("FAIL full_wb_err got %b want 1", wb_err); else checks_passed++;
        for (int k = 0; k < 7; k++) begin
            cpl_valid = (k < 4);
            cpl_rd_valid = 0;
            cpl_fpr_data = 16'(16'h1111 * (k + 1));
            #1;
            checks_total++; if (fpr_we !== (k >= LAT && k <= LAT + 3)) $display("FAIL b2b_we k=%0d got %b want %b", k, fpr_we, (k >= LAT && k <= LAT + 3)); else checks_passed++;
            if (k >= LAT && k <= LAT + 3) begin
                exp_d = 16'(16'h1111 * (k - LAT + 1));
                checks_total++; if (fpr_waddr !== 5'(k - LAT + 1) || fpr_wdata !== exp_d) $display("FAIL b2b_payload k=%0d got %0d/%h want %0d/%h", k, fpr_waddr, fpr_wdata, k - LAT + 1, exp_d); else checks_passed++;
            end
            checks_total++; if (disp_ready !== (k >= LAT + 1)) $display("FAIL b2b_disp_ready k=%0d got %b want %b", k, disp_ready, (k >= LAT + 1)); else checks_passed++;
            cyc();
        end
        cpl_valid = 0;
        #1;
        checks_total++; if (busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy); else checks_passed++;
        checks_total++; if (fpr_we !== 1'b0) $display("FAIL b2b_extra_write got %b want 0", fpr_we); else checks_passed++;
    endtask

    task automatic test_flags();
        do_reset();
        dispatch(5'd1, 1'b0);
        dispatch(5'd2, 1'b0);
        cpl_valid = 1; cyc();
        cpl_flags = 5'b00001; cyc();
        cpl_valid = 0; cpl_flags = 5'b10000; #1;
        checks_total++; if (fflags !== 5'b00001) $display("FAIL flags_first got %b want 00001", fflags); else checks_passed++;
        cyc();
        cpl_flags = 5'b0; #1;
        checks_total++; if (fflags !== 5'b10001) $display("FAIL flags_accrue got %b want 10001", fflags); else checks_passed++;
        dispatch(5'd3, 1'b0);
        cpl_valid = 1; cpl_iv_exc = 1; cyc();
        checks_total++; if (iv_exc_pend !== 1'b1) $display("FAIL flags_iv_set got %b want 1", iv_exc_pend); else checks_passed++;
        cpl_valid = 0; cpl_iv_exc = 0; cpl_flags = 5'b10000;
        csr_fflags_we = 1; csr_fflags_wdata = 5'b00000; cyc();
        csr_fflags_we = 0; cpl_flags = 5'b0; #1;
        checks_total++; if (fflags !== 5'b10000) $display("FAIL flags_csr_accrue got %b want 10000", fflags); else checks_passed++;
        checks_total++; if (iv_exc_pend !== 1'b0) $display("FAIL flags_iv_clear got %b want 0", iv_exc_pend); else checks_passed++;
        csr_fflags_we = 1; csr_fflags_wdata = 5'b00101; cyc();
        csr_fflags_we = 0; #1;
        checks_total++; if (fflags !== 5'b00101) $display("FAIL flags_csr_write got %b want 00101", fflags); else checks_passed++;
        for (int k = 0; k < 4; k++) cyc();
        checks_total++; if (busy !== 1'b0) $display("FAIL flags_busy got %b want 0", busy); else checks_passed++;
    endtask

    task automatic test_empty_cpl();
        do_reset();
        cpl_valid = 1; cpl_fpr_data = 16'h1234; #1;
        checks_total++; if (fpr_we !== 1'b0) $display("FAIL orphan_we0 got %b want 0", fpr_we); else checks_passed++;
        cyc();
        cpl_valid = 0; #1;
        checks_total++; if (wb_err !== 1'b1) $display("FAIL orphan_wb_err got %b want 1", wb_err); else checks_passed++;
        for (int k = 0; k < 3; k++) begin
            checks_total++; if (fpr_we !== 1'b0 || gpr_wb_valid !== 1'b0) $display("FAIL orphan_write k=%0d got %b/%b want 0/0", k, fpr_we, gpr_wb_valid); else checks_passed++;
            cyc();
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        dispatch(5'd7, 1'b0);
        cpl_valid = 1; cpl_rd_valid = 1; cpl_fpr_data = 16'hABCD; cpl_gpr_data = 32'hDEAD_BEEF; gpr_wb_ready = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) cpl_valid = 0;
            #1;
            checks_total++; if (fpr_we !== (k == LAT) || gpr_wb_valid !== 1'b0) $display("FAIL mismatch_path k=%0d got we=%b gv=%b want %b/0", k, fpr_we, gpr_wb_valid, (k == LAT)); else checks_passed++;
            if (k == LAT) begin
                checks_total++; if (fpr_waddr !== 5'd7 || fpr_wdata !== 16'hABCD) $display("FAIL mismatch_payload got %0d/%h want 7/abcd", fpr_waddr, fpr_wdata); else checks_passed++;
            end
            cyc();
        end
        gpr_wb_ready = 0;
        checks_total++; if (wb_err !== 1'b1) $display("FAIL mismatch_wb_err got %b want 1", wb_err); else checks_passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dispatch(5'd12, 1'b1);
        cpl_valid = 1; cpl_rd_valid = 1; cpl_gpr_data = 32'h55; gpr_wb_ready = 0;
        cyc(); cpl_valid = 0; cyc();
        checks_total++; if (gpr_wb_valid !== 1'b1) $display("FAIL rstmid_pre_valid got %b want 1", gpr_wb_valid); else checks_passed++;
        dispatch(5'd13, 1'b0);
        rst = 1; cyc(); rst = 0; #1;
        checks_total++; if (gpr_wb_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", gpr_wb_valid); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else checks_passed++;
        checks_total++; if (disp_ready !== 1'b1) $display("FAIL rstmid_disp_ready got %b want 1", disp_ready); else checks_passed++;
        cyc(); cyc();
        checks_total++; if (gpr_wb_valid !== 1'b0 || fpr_we !== 1'b0) $display("FAIL rstmid_residue got %b/%b want 0/0", gpr_wb_valid, fpr_we); else checks_passed++;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_fpr_single();
        test_gpr_stall();
        test_gpr_x0();
        test_back_to_back();
        test_flags();
        test_empty_cpl();
        test_mismatch();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/fpu_wb_retire.md
Name: fpu_wb_retire

Overview:
- Consumer end of the FPU execute interface.
- Captures the destination tag at dispatch and pairs it with the in-order completion stream (FPR result, GPR result, flags) from the FPU execute unit.
- Retires FPR results to the FP register file and GPR results through a valid/ready port to the integer writeback arbiter.
- Accrues fflags and applies dispatch backpressure.

Parameters:
- FPLEN, 16, FP register width.
- DEPTH, 4, maximum in-flight plus unretired operations (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- disp_valid  in  1  FPU op dispatched this cycle
- disp_rd  in  5  destination register index
- disp_to_gpr  in  1  1 = integer destination (feq/flt/fle/fclass/fmv.x/fcvt.w)
- disp_ready  out  1  credit available; decode must not dispatch when 0
- cpl_valid  in  1  execute-unit complete pulse
- cpl_rd_valid  in  1  completion targets GPR
- cpl_fpr_data  in  FPLEN  FP result
- cpl_gpr_data  in  32  integer result
- cpl_flags  in  5  flags, valid the cycle AFTER cpl_valid
- cpl_iv_exc  in  1  invalid-op exception, aligned with cpl_valid
- fpr_we  out  1  FP regfile write enable
- fpr_waddr  out  5
- fpr_wdata  out  FPLEN
- gpr_wb_valid  out  1
- gpr_wb_ready  in  1
- gpr_wb_addr  out  5
- gpr_wb_data  out  32
- csr_fflags_we  in  1  CSR write to fflags
- csr_fflags_wdata  in  5
- fflags  out  5  accrued flags (NV,DZ,OF,UF,NX)
- iv_exc_pend  out  1  sticky, cleared by csr_fflags_we
- wb_err  out  1  sticky protocol error
- busy  out  1  any tag or result outstanding

Behaviour:
- Reset (rst=1 at clk edge): all queues empty, credit=DEPTH.
  - Outputs: fpr_we=0, gpr_wb_valid=0, fflags=0, iv_exc_pend=0, wb_err=0, busy=0, disp_ready=1.
  - Reset mid-operation discards all in-flight tags and results.
- Credit counter 0..DEPTH:
  - Decremented on disp_valid & disp_ready.
  - Incremented on retire (fpr_we, or gpr_wb_valid & gpr_wb_ready).
  - Simultaneous decrement and increment leave it unchanged.
  - disp_ready = (credit != 0).
  - disp_valid while credit=0 is ignored and sets wb_err.
- Tag FIFO (DEPTH entries of {rd, to_gpr}):
  - Pushed on accepted dispatch.
  - Popped on cpl_valid.
  - Push and pop in the same cycle are legal at any occupancy, including full and empty.
- Completion pairing:
  - On cpl_valid, the head tag plus the selected data (to_gpr ? cpl_gpr_data : cpl_fpr_data zero-extended to 32) is pushed into the result FIFO (DEPTH entries).
  - If cpl_rd_valid ≠ head to_gpr: the tag wins and wb_err is set.
  - cpl_valid with an empty tag FIFO: completion dropped, wb_err set.
- Retire FSM, operating on the result FIFO head:
  - IDLE: FIFO empty → stay. Head FPR → FPR_WR. Head GPR → GPR_REQ.
  - FPR_WR: fpr_we=1 for exactly one cycle; pop; then re-evaluate (back-to-back FPR writes every cycle).
  - GPR_REQ: gpr_wb_valid=1 with addr/data held stable until gpr_wb_ready. On handshake, pop and re-evaluate next cycle.
  - Never deassert valid without a handshake.
- Latency: cpl_valid → fpr_we is 2 cycles minimum. cpl_valid → gpr_wb_valid is 2 cycles minimum.
- GPR writes to x0: retired normally (the handshake occurs), with gpr_wb_addr=0; the arbiter discards them.
- Flags:
  - A 1-cycle pending bit set by cpl_valid.
  - Next cycle: fflags |= cpl_flags.
  - Same cycle as csr_fflags_we: fflags = csr_fflags_wdata | cpl_flags (accrual not lost).
  - cpl_iv_exc sets iv_exc_pend.
- busy = tag FIFO non-empty | result FIFO non-empty | flag pending.

Optional Feature:
- FPU_WB_BYPASS_EN
  - Defined: when the result FIFO is empty, the FSM is IDLE, and the completion targets an FPR, fpr_we is asserted in the cpl_valid cycle itself (latency 0) and nothing is pushed.
  - Undefined: all completions go through the FIFO (latency ≥2 as above).

Decomposition:
- Shared package fpu_wb_pkg:
  - Retire FSM state enum (IDLE, FPR_WR, GPR_REQ).
  - Flag bit index constants (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - Result-entry struct {to_gpr, rd[4:0], data[31:0]}.
- One natural sub-module: fpu_wb_fifo, a parameterised sync FIFO with push/pop/full/empty, instantiated for both tags and results.

Test Plan:
- Reset, then dispatch rd=5 FPR; cpl_valid with fpr data 16'h3C00 → fpr_we=1, waddr=5, wdata=3C00 two cycles later; credit returns to 4.
- Dispatch rd=10 GPR; complete with 32'h1; hold gpr_wb_ready=0 for 3 cycles → gpr_wb_valid stays 1 with stable addr/data, then one handshake only.
- Dispatch 4 ops without completion → disp_ready=0; a 5th disp_valid sets wb_err; one retire → disp_ready=1.
- cpl_flags=5'b00001 followed by 5'b10000 on the next completion → fflags=5'b10001; csr_fflags_we with 0 in the accrual cycle → fflags=5'b10000.
- cpl_valid with an empty tag FIFO → no write, wb_err=1; assert rst mid-GPR_REQ → gpr_wb_valid=0 next cycle, busy=0.
- With FPU_WB_BYPASS_EN: empty queue and FPR completion → fpr_we in the same cycle as cpl_valid.
